alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the core's 16-bit ALU.
- Generalised WIDTH, 3-bit opcode (8 ops) and a full flag set (z, n, c, v).
- Single-cycle ops plus an iterative multi-cycle multiply.
- Sits between operand fetch and writeback in each core.
- valid/ready on both sides lets it stall the core pipeline.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_mul_seq.sv | 50 +++++
 rtl/alu_pipe.sv | 84 ++++++++
 tb/tb_alu_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and default width shared by alu_pipe and alu_mul_seq
package alu_pkg;
  localparam int ALU_WIDTH_DEF = 16;
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_MUL  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;
  localparam logic [2:0] ALU_SHL  = 3'd7;
  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_HOLD} alu_state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle, result held while stalled
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH);
  logic run, hold, last;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, a_sh, acc_nx;
  logic [WIDTH-1:0] b_sh;
  always_comb begin
    acc_nx = acc + (b_sh[0] ? a_sh : '0);
    last = run && cnt == CW'(WIDTH - 1);
    done = last || hold;
    prod = hold ? acc : acc_nx;
  end
  always_ff @(posedge clock)
    if (reset) begin
      run <= 1'b0;
      hold <= 1'b0;
      cnt <= '0;
      acc <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (start) begin
      run <= 1'b1;
      hold <= 1'b0;
      cnt <= '0;
      acc <= '0;
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
    end else if (run) begin
      acc <= acc_nx;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt <= cnt + CW'(1);
      run <= !last;
      hold <= last && stall;
    end else if (hold && !stall) begin
      hold <= 1'b0;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready WIDTH-bit ALU with iterative MUL; define ALU_SAT_EN for saturating ADD/SUB/MUL
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  alu_state_t state, state_nx;
  logic out_free, accept, mul_start, mul_done, load, mul_c, c_nx, v_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0] sum, diff, shl;
  logic [WIDTH-1:0] raw, res;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock(clock),
    .reset(reset),
    .start(mul_start),
    .stall(!out_free),
    .a(in1),
    .b(in2),
    .done(mul_done),
    .prod(prod)
  );
  always_comb begin
    out_free = !out_valid || out_ready;
    busy = state != IDLE;
    in_ready = !busy && out_free;
    accept = in_valid && in_ready;
    mul_start = accept && alu_op == ALU_MUL;
    load = (accept && alu_op != ALU_MUL) || (busy && mul_done && out_free);
    sum = {1'b0, in1} + {1'b0, in2};
    diff = {1'b0, in1} - {1'b0, in2};
    shl = {1'b0, in1} << in2[SHW-1:0];
    mul_c = |prod[2*WIDTH-1:WIDTH];
    c_nx = busy ? mul_c : alu_op == ALU_ADD ? sum[WIDTH] : alu_op == ALU_SUB ? diff[WIDTH] :
           alu_op == ALU_SHL ? shl[WIDTH] : 1'b0;
    v_nx = busy ? 1'b0 :
           alu_op == ALU_ADD ? (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]) :
           alu_op == ALU_SUB ? (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]) : 1'b0;
    raw = busy ? prod[WIDTH-1:0] : alu_op == ALU_ADD ? sum[WIDTH-1:0] : alu_op == ALU_SUB ? diff[WIDTH-1:0] :
          alu_op == ALU_AND ? in1 & in2 : alu_op == ALU_OR ? in1 | in2 : alu_op == ALU_XOR ? in1 ^ in2 :
          alu_op == ALU_SHL ? shl[WIDTH-1:0] : in1;
`ifdef ALU_SAT_EN
    res = busy ? (c_nx ? '1 : raw) : alu_op == ALU_ADD && c_nx ? '1 : alu_op == ALU_SUB && c_nx ? '0 : raw;
`else
    res = raw;
`endif
    state_nx = state == IDLE ? (mul_start ? MUL_RUN : IDLE) :
               state == MUL_RUN ? (mul_done ? (out_free ? IDLE : MUL_HOLD) : MUL_RUN) :
               out_free ? IDLE : MUL_HOLD;
  end
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_nx;
  always_ff @(posedge clock)
    if (reset) begin
      out_valid <= 1'b0;
      out <= '0;
      {z, n, c, v} <= 4'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out <= res;
      z <= res == '0;
      n <= res[WIDTH-1];
      c <= c_nx;
      v <= v_nx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;
  import alu_pkg::*;
  localparam int W = 16;
`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct packed {
    logic [W-1:0] r;
    logic z, n, c, v;
  } res_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic rand_bp = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic [2:0] alu_op = ALU_PASS;
  logic in_ready, out_valid, z, n, c, v, busy;
  logic [W-1:0] out;
  int vectors = 0;
  int miscompares = 0;
  res_t q[$];
  res_t held;
  logic hv = 1'b0;
  always #5 clock = ~clock;
  alu_pipe #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in1(in1),
    .in2(in2),
    .alu_op(alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out),
    .z(z),
    .n(n),
    .c(c),
    .v(v),
    .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua = a;
    longint ub = b;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint lim = longint'(1) << (W - 1);
    longint full;
    int amt = int'(b) % W;
    res_t m;
    m.c = 1'b0;
    m.v = 1'b0;
    case (op)
      ALU_ADD: begin
        full = ua + ub;
        m.c = full >= (longint'(1) << W);
        m.v = (sa + sb) >= lim || (sa + sb) < -lim;
      end
      ALU_SUB: begin
        full = ua - ub;
        m.c = ua < ub;
        m.v = (sa - sb) >= lim || (sa - sb) < -lim;
      end
      ALU_MUL: begin
        full = ua * ub;
        m.c = full >= (longint'(1) << W);
      end
      ALU_AND: full = ua & ub;
      ALU_OR:  full = ua | ub;
      ALU_XOR: full = ua ^ ub;
      ALU_SHL: begin
        full = ua << amt;
        m.c = amt != 0 && ((ua >> (W - amt)) & 1) != 0;
      end
      default: full = ua;
    endcase
    m.r = full[W-1:0];
    if (SAT && m.c && (op == ALU_ADD || op == ALU_MUL)) m.r = '1;
    if (SAT && m.c && op == ALU_SUB) m.r = '0;
    m.z = m.r == '0;
    m.n = m.r[W-1];
    return m;
  endfunction
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      hv = 1'b0;
    end else begin
      if (out_valid) begin
        if (hv) check("hold", {out, z, n, c, v}, held);
        if (out_ready) begin
          hv = 1'b0;
          if (q.size() == 0) check("spurious", out_valid, 0);
          else check("result", {out, z, n, c, v}, q.pop_front());
        end else begin
          held = {out, z, n, c, v};
          hv = 1'b1;
        end
      end else begin
        hv = 1'b0;
      end
      if (in_valid && in_ready) q.push_back(model(alu_op, in1, in2));
    end
  end
  always @(posedge clock)
    if (rand_bp) begin
      #2;
      out_ready = $urandom_range(0, 3) != 0;
    end
  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clock);
      #2;
    end
  endtask
  task automatic op1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    alu_op = op;
    in1 = a;
    in2 = b;
    check("in_ready_at_offer", in_ready, 1);
    cyc(1);
    in_valid = 1'b0;
  endtask
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    alu_op = op;
    in1 = a;
    in2 = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (in_ready) begin
        cyc(1);
        in_valid = 1'b0;
        return;
      end
      cyc(1);
    end
    check("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask
  initial begin
    cyc(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out, 0);
    check("rst_flags", {z, n, c, v}, 0);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    op1(ALU_ADD, 3, 2);
    check("add_valid", out_valid, 1);
    check("add_out", {out, z, c}, {16'd5, 1'b0, 1'b0});
    cyc(1);
    check("add_valid_drop", out_valid, 0);
    op1(ALU_SUB, 3, 3);
    check("sub_zero", {out, z}, {16'd0, 1'b1});
    op1(ALU_SUB, 4, 6);
    check("sub_borrow", {out, z, n, c, v}, {SAT ? 16'h0000 : 16'hFFFE, SAT, !SAT, 1'b1, 1'b0});
    op1(ALU_ADD, 16'h7FFF, 1);
    check("add_ovf", {out, z, n, c, v}, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    op1(ALU_ADD, 16'hFFFF, 1);
    check("add_carry", {out, z, n, c, v}, {SAT ? 16'hFFFF : 16'h0000, !SAT, SAT, 1'b1, 1'b0});
    op1(ALU_MUL, 300, 300);
    check("mul_busy", {busy, in_ready}, 2'b10);
    cyc(15);
    check("mul_not_early", out_valid, 0);
    cyc(1);
    check("mul_valid", {out_valid, busy}, 2'b10);
    check("mul_out", {out, c, v}, {SAT ? 16'hFFFF : 16'h5F90, 1'b1, 1'b0});
    cyc(1);
    out_ready = 1'b0;
    op1(ALU_ADD, 1, 1);
    in_valid = 1'b1;
    alu_op = ALU_MUL;
    in1 = 2;
    in2 = 3;
    cyc(3);
    check("bp_in_ready", in_ready, 0);
    check("bp_held", {out_valid, out}, {1'b1, 16'd2});
    out_ready = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    check("bp_mul_busy", busy, 1);
    cyc(15);
    check("bp_mul_not_early", out_valid, 0);
    cyc(1);
    check("bp_mul_out", {out_valid, out}, {1'b1, 16'd6});
    cyc(1);
    op1(ALU_MUL, 5, 7);
    cyc(4);
    reset = 1'b1;
    cyc(1);
    check("abort_state", {out_valid, busy, in_ready}, 3'b001);
    check("abort_out", out, 0);
    reset = 1'b0;
    cyc(20);
    check("abort_no_stale", out_valid, 0);
    op1(ALU_SHL, 16'h8001, 1);
    check("shl_carry", {out, c}, {16'h0002, 1'b1});
    op1(ALU_SHL, 16'h8001, 0);
    check("shl_zero_amt", {out, c}, {16'h8001, 1'b0});
    cyc(1);
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      if (op == ALU_MUL && $urandom_range(0, 2) != 0) op = ALU_ADD;
      a = $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 3)) ^ {W{$urandom_range(0, 1) == 1}};
      b = $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 3)) ^ {W{$urandom_range(0, 1) == 1}};
      issue(op, a, b);
      cyc($urandom_range(0, 2));
    end
    rand_bp = 1'b0;
    cyc(1);
    out_ready = 1'b1;
    cyc(40);
    check("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
